// File: rtl/line_word_streamer_pkg.sv
// Shared types and sizes for the line-to-word streamer.
package line_word_streamer_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 16;
    localparam int unsigned IDX_W      = $clog2(LINE_WORDS);
    localparam int unsigned PTR_W      = IDX_W + 1;

    typedef logic [WORD_W-1:0]        word_t;
    typedef word_t [LINE_WORDS-1:0]   line_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef logic [PTR_W-1:0]         ptr_t;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } stream_state_t;

endpackage

// File: rtl/line_word_streamer_if.sv
// Load-side and word-side handshake bundle of the line streamer.
interface line_word_streamer_if;
    import line_word_streamer_pkg::*;

    logic  load_valid;
    logic  load_ready;
    line_t load_data;
    logic  pair_en;
    logic  out_valid;
    logic  out_valid2;
    logic  out_ready;
    word_t out_data;
    word_t out_data2;
    idx_t  out_index;
    idx_t  out_index2;
    logic  out_last;

    modport slave (
        input  load_valid, load_data, pair_en, out_ready,
        output load_ready, out_valid, out_valid2, out_data, out_data2,
               out_index, out_index2, out_last
    );

    modport master (
        output load_valid, load_data, pair_en, out_ready,
        input  load_ready, out_valid, out_valid2, out_data, out_data2,
               out_index, out_index2, out_last
    );

endinterface

// File: rtl/line_word_streamer_mux.sv
// Combinational word selector: picks one word out of a packed line.
module line_word_streamer_mux
    import line_word_streamer_pkg::*;
(
    input  line_t line,
    input  idx_t  index,
    output word_t word
);

    assign word = line[index];

endmodule

// File: rtl/line_word_streamer.sv
// Captures a full line while idle, then streams it out one or two words per beat.
module line_word_streamer
    import line_word_streamer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    line_word_streamer_if.slave  bus
);

    stream_state_t state;
    ptr_t          ptr;
    line_t         line_buf;

    idx_t  idx0;
    idx_t  idx1;
    word_t word0;
    word_t word1;
    logic  streaming;
    logic  second_ok;
    ptr_t  step;
    logic  last;
    logic  fire;

    assign streaming = (state == S_STREAM);
    assign idx0      = ptr[IDX_W-1:0];
    assign idx1      = idx0 + IDX_W'(1);

    // A second word exists only while at least two words remain.
    assign second_ok = bus.pair_en && (ptr <= PTR_W'(LINE_WORDS - 2));
    assign step      = PTR_W'(1) + PTR_W'(streaming && second_ok);
    assign last      = streaming && ((ptr + step) == PTR_W'(LINE_WORDS));
    assign fire      = streaming && bus.out_ready;

    line_word_streamer_mux u_mux0 (
        .line  (line_buf),
        .index (idx0),
        .word  (word0)
    );

    line_word_streamer_mux u_mux1 (
        .line  (line_buf),
        .index (idx1),
        .word  (word1)
    );

    assign bus.load_ready = !streaming;
    assign bus.out_valid  = streaming;
    assign bus.out_valid2 = streaming && second_ok;
    assign bus.out_data   = word0;
    assign bus.out_data2  = word1;
    assign bus.out_index  = idx0;
    assign bus.out_index2 = idx1;
    assign bus.out_last   = last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_valid) begin
                        line_buf <= bus.load_data;
                        ptr      <= '0;
                        state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (fire) begin
                        ptr <= ptr + step;
                        if (last) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
